// File: rtl/adc_scan_scheduler.sv
// Scan scheduler for the I2C ADC front-end: on each period tick, converts every channel
// set in ch_mask (ascending), streams the results out and tracks timeout/NACK/missed-tick errors.
module adc_scan_scheduler #(
  parameter int unsigned PERIOD_W    = 22,
  parameter int unsigned TIMEOUT_CYC = 4096,
  parameter int unsigned CNT_W       = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic [3:0]          ch_mask,
  input  logic [PERIOD_W-1:0] period,
  input  logic                err_clr,
  output logic                adc_start,
  output logic [1:0]          adc_channel,
  input  logic                adc_done,
  input  logic [11:0]         adc_data,
  input  logic                adc_nack,
  output logic                smp_valid,
  input  logic                smp_ready,
  output logic [11:0]         smp_data,
  output logic [1:0]          smp_ch,
  output logic                scan_done,
  output logic                timeout_err,
  output logic                nack_err,
  output logic [CNT_W-1:0]    missed_ticks
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, PUSH} state_e;

  state_e              state_q, state_d;
  logic [PERIOD_W-1:0] timer_q, timer_d, period_eff;
  logic                pending_q, pending_d, tick;
  logic [3:0]          scan_mask_q, scan_mask_d, rem_mask;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic                adc_start_q, adc_start_d;
  logic [1:0]          adc_channel_q, adc_channel_d;
  logic                smp_valid_q, smp_valid_d;
  logic [11:0]         smp_data_q, smp_data_d;
  logic [1:0]          smp_ch_q, smp_ch_d;
  logic                scan_done_q, scan_done_d;
  logic                timeout_err_q, timeout_err_d;
  logic                nack_err_q, nack_err_d;
  logic [CNT_W-1:0]    missed_q, missed_d;
  logic                consume, advance, set_to, set_nack;

  function automatic logic [1:0] lowest(input logic [3:0] m);
    if (m[0])      return 2'd0;
    else if (m[1]) return 2'd1;
    else if (m[2]) return 2'd2;
    else           return 2'd3;
  endfunction

  // Period timer and tick bookkeeping; disabling discards any pending tick
  always_comb begin
    period_eff = (period == '0) ? PERIOD_W'(1) : period;
    tick       = enable && (timer_q >= period_eff - PERIOD_W'(1));
    timer_d    = (!enable || tick) ? '0 : timer_q + PERIOD_W'(1);
    if (!enable)       pending_d = 1'b0;
    else if (tick)     pending_d = 1'b1;
    else if (consume)  pending_d = 1'b0;
    else               pending_d = pending_q;
    if (tick && pending_q)
      missed_d = (missed_q == '1) ? missed_q : missed_q + CNT_W'(1);
    else if (err_clr)
      missed_d = '0;
    else
      missed_d = missed_q;
    timeout_err_d = set_to   | (timeout_err_q & ~err_clr);
    nack_err_d    = set_nack | (nack_err_q & ~err_clr);
  end

  // Scan sequencer
  always_comb begin
    state_d       = state_q;
    scan_mask_d   = scan_mask_q;
    tmo_d         = tmo_q;
    adc_start_d   = 1'b0;
    adc_channel_d = adc_channel_q;
    smp_valid_d   = smp_valid_q;
    smp_data_d    = smp_data_q;
    smp_ch_d      = smp_ch_q;
    scan_done_d   = 1'b0;
    consume       = 1'b0;
    advance       = 1'b0;
    set_to        = 1'b0;
    set_nack      = 1'b0;
    rem_mask      = '0;

    case (state_q)
      IDLE: begin
        if (pending_q && enable) begin
          consume     = 1'b1;
          scan_mask_d = ch_mask;
          if (ch_mask != '0) begin
            state_d       = ISSUE;
            adc_channel_d = lowest(ch_mask);
            adc_start_d   = 1'b1;
          end
        end
      end
      ISSUE: begin
        state_d = WAIT_DONE;
        tmo_d   = '0;
      end
      WAIT_DONE: begin
        if (adc_done) begin
          if (adc_nack) begin
            set_nack = 1'b1;
            advance  = 1'b1;
          end else begin
            smp_data_d  = adc_data;
            smp_ch_d    = adc_channel_q;
            smp_valid_d = 1'b1;
            state_d     = PUSH;
          end
        end else if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
          set_to  = 1'b1;
          advance = 1'b1;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      PUSH: begin
        if (smp_valid_q && smp_ready) begin
          smp_valid_d = 1'b0;
          advance     = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Retire current channel; a disabled scheduler abandons the rest of the scan silently
    if (advance) begin
      rem_mask    = scan_mask_q & ~(4'b0001 << adc_channel_q);
      scan_mask_d = rem_mask;
      if (!enable) begin
        state_d = IDLE;
      end else if (rem_mask != '0) begin
        state_d       = ISSUE;
        adc_channel_d = lowest(rem_mask);
        adc_start_d   = 1'b1;
      end else begin
        state_d     = IDLE;
        scan_done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      timer_q       <= '0;
      pending_q     <= 1'b0;
      scan_mask_q   <= '0;
      tmo_q         <= '0;
      adc_start_q   <= 1'b0;
      adc_channel_q <= '0;
      smp_valid_q   <= 1'b0;
      smp_data_q    <= '0;
      smp_ch_q      <= '0;
      scan_done_q   <= 1'b0;
      timeout_err_q <= 1'b0;
      nack_err_q    <= 1'b0;
      missed_q      <= '0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      pending_q     <= pending_d;
      scan_mask_q   <= scan_mask_d;
      tmo_q         <= tmo_d;
      adc_start_q   <= adc_start_d;
      adc_channel_q <= adc_channel_d;
      smp_valid_q   <= smp_valid_d;
      smp_data_q    <= smp_data_d;
      smp_ch_q      <= smp_ch_d;
      scan_done_q   <= scan_done_d;
      timeout_err_q <= timeout_err_d;
      nack_err_q    <= nack_err_d;
      missed_q      <= missed_d;
    end
  end

  assign adc_start    = adc_start_q;
  assign adc_channel  = adc_channel_q;
  assign smp_valid    = smp_valid_q;
  assign smp_data     = smp_data_q;
  assign smp_ch       = smp_ch_q;
  assign scan_done    = scan_done_q;
  assign timeout_err  = timeout_err_q;
  assign nack_err     = nack_err_q;
  assign missed_ticks = missed_q;

endmodule
